// File: rtl/ifu_ysyx.sv
// ifu_ysyx: instruction fetch unit for the multi-cycle NPC core.
//
// Holds the PC and issues one word read to instruction memory at a time.
// Each fetched instruction is presented to decode with its PC over a
// valid/ready handshake. The unit then waits for execute to commit a
// next-PC before it fetches again, so at most one instruction is ever in
// flight. It never increments the PC itself. All outputs are registered.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_req_*        read request (valid/ready) and word-aligned imem_addr
//   imem_rsp_*        read response: one-cycle valid pulse, data, access fault
//   inst_*            instruction to decode (valid/ready), word, PC and fault
//                     code (00 none, 01 access fault, 10 misaligned PC)
//   commit_*          one-cycle pulse from execute carrying the next PC
//
// Optional feature (macro IFU_PERF_EN): adds the perf_fetch_cnt,
// perf_mem_stall and perf_dec_stall counters and their output ports.
module ifu_ysyx #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h80000000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [1:0]      inst_fault,
  input  logic            commit_valid,
  input  logic [XLEN-1:0] commit_npc
`ifdef IFU_PERF_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_mem_stall,
  output logic [31:0]     perf_dec_stall
`endif
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, EXEC} state_t;

  localparam logic [1:0] FAULT_NONE  = 2'b00;
  localparam logic [1:0] FAULT_ACC   = 2'b01;
  localparam logic [1:0] FAULT_ALIGN = 2'b10;

  state_t          state, nextState;
  logic [XLEN-1:0] pc;
  logic            npcAligned;

  assign npcAligned = (commit_npc[1:0] == 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: nextState = REQ;
      REQ:  if (imem_req_ready) nextState = WAIT;
      WAIT: if (imem_rsp_valid) nextState = OUT;
      OUT:  if (inst_ready)     nextState = EXEC;
      EXEC: if (commit_valid)   nextState = npcAligned ? REQ : OUT;
      default: nextState = IDLE;
    endcase
  end

  // Registered datapath and outputs, updated alongside the state transitions
  // above. Inputs that do not matter in the current state (stale responses,
  // commits outside EXEC, ready with nothing valid) are dropped here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc             <= RESET_PC;
      imem_req_valid <= 1'b0;
      imem_addr      <= '0;
      inst_valid     <= 1'b0;
      inst           <= '0;
      inst_pc        <= '0;
      inst_fault     <= FAULT_NONE;
    end else begin
      case (state)
        IDLE: begin
          imem_addr      <= pc;
          imem_req_valid <= 1'b1;
        end
        REQ: begin
          if (imem_req_ready) imem_req_valid <= 1'b0;
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            inst       <= imem_rsp_err ? 32'h0 : imem_rsp_data;
            inst_fault <= imem_rsp_err ? FAULT_ACC : FAULT_NONE;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
          end
        end
        OUT: begin
          if (inst_ready) inst_valid <= 1'b0;
        end
        EXEC: begin
          if (commit_valid) begin
            pc <= commit_npc;
            if (npcAligned) begin
              imem_addr      <= commit_npc;
              imem_req_valid <= 1'b1;
            end else begin
              // Misaligned target: report the fault straight to decode
              // without touching memory; execute answers with a trap vector.
              inst       <= 32'h0;
              inst_pc    <= commit_npc;
              inst_fault <= FAULT_ALIGN;
              inst_valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IFU_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_mem_stall <= '0;
      perf_dec_stall <= '0;
    end else begin
      if (state == WAIT && imem_rsp_valid)   perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (state == REQ || state == WAIT)     perf_mem_stall <= perf_mem_stall + 32'd1;
      if (state == OUT && !inst_ready)       perf_dec_stall <= perf_dec_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifu_ysyx.sv
// Self-checking bench for ifu_ysyx. A transaction-level model tracks only
// the architectural PC; each fetch, decode handshake and commit is driven as
// one transaction with random memory/decode latencies. Expected outputs come
// from the fetch rules applied to that PC.
module tb_ifu_ysyx;
  localparam logic [31:0] RST_PC = 32'h80000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid, imem_rsp_err;
  logic [31:0] imem_rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic [1:0]  inst_fault;
  logic        commit_valid;
  logic [31:0] commit_npc;
`ifdef IFU_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_mem_stall, perf_dec_stall;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] pcM;

  ifu_ysyx dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_fault(inst_fault),
    .commit_valid(commit_valid), .commit_npc(commit_npc)
`ifdef IFU_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_mem_stall(perf_mem_stall),
    .perf_dec_stall(perf_dec_stall)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkIdleOuts(input string tag);
    chk({tag, ".req_valid"},  {31'h0, imem_req_valid}, 32'h0);
    chk({tag, ".inst_valid"}, {31'h0, inst_valid},     32'h0);
  endtask

  // Decode side: stall `stall` cycles (with ignored commit / stale response
  // pulses), then accept. Instruction outputs must hold throughout.
  task automatic deliver(input int stall, input logic [31:0] eInst,
                         input logic [31:0] ePc, input logic [1:0] eFault);
    for (int i = 0; i < stall; i++) begin
      inst_ready     = 1'b0;
      commit_valid   = (i == 0) || ($urandom_range(0, 2) == 0);
      commit_npc     = $urandom;
      imem_rsp_valid = ($urandom_range(0, 2) == 0);
      imem_rsp_data  = $urandom;
      step();
      commit_valid   = 1'b0;
      imem_rsp_valid = 1'b0;
      chk("out.hold_valid", {31'h0, inst_valid}, 32'h1);
      chk("out.hold_inst",  inst,    eInst);
      chk("out.hold_pc",    inst_pc, ePc);
      chk("out.hold_fault", {30'h0, inst_fault}, {30'h0, eFault});
      chk("out.no_req",     {31'h0, imem_req_valid}, 32'h0);
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("out.accept", {31'h0, inst_valid}, 32'h0);
  endtask

  // Memory side for one fetch of pcM; leaves the instruction presented.
  task automatic fetch(input int reqDelay, input int lat, input logic [31:0] data,
                       input logic err, input int decStall);
    logic [31:0] eInst;
    for (int i = 0; i < reqDelay; i++) begin
      chk("req.valid", {31'h0, imem_req_valid}, 32'h1);
      chk("req.addr",  imem_addr, pcM);
      step();
    end
    chk("req.valid", {31'h0, imem_req_valid}, 32'h1);
    chk("req.addr",  imem_addr, pcM);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk("req.drop", {31'h0, imem_req_valid}, 32'h0);
    for (int i = 0; i < lat; i++) begin
      commit_valid = ($urandom_range(0, 3) == 0);
      commit_npc   = $urandom;
      step();
      commit_valid = 1'b0;
      chkIdleOuts("wait");
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    imem_rsp_err   = err;
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    eInst = err ? 32'h0 : data;
    chk("rsp.valid", {31'h0, inst_valid}, 32'h1);
    chk("rsp.inst",  inst, eInst);
    chk("rsp.pc",    inst_pc, pcM);
    chk("rsp.fault", {30'h0, inst_fault}, err ? 32'h1 : 32'h0);
    deliver(decStall, eInst, pcM, err ? 2'b01 : 2'b00);
  endtask

  // Execute side: idle a few cycles, then commit npc.
  task automatic commitTo(input logic [31:0] npc, input int idle);
    for (int i = 0; i < idle; i++) begin
      imem_rsp_valid = ($urandom_range(0, 1) == 0);
      inst_ready     = ($urandom_range(0, 1) == 0);
      step();
      imem_rsp_valid = 1'b0;
      inst_ready     = 1'b0;
      chkIdleOuts("exec");
    end
    commit_valid = 1'b1;
    commit_npc   = npc;
    step();
    commit_valid = 1'b0;
    pcM = npc;
    if (npc[1:0] == 2'b00) begin
      chk("commit.req_valid", {31'h0, imem_req_valid}, 32'h1);
      chk("commit.req_addr",  imem_addr, npc);
      chk("commit.no_inst",   {31'h0, inst_valid}, 32'h0);
    end else begin
      chk("misal.valid",  {31'h0, inst_valid}, 32'h1);
      chk("misal.inst",   inst, 32'h0);
      chk("misal.pc",     inst_pc, npc);
      chk("misal.fault",  {30'h0, inst_fault}, 32'h2);
      chk("misal.no_req", {31'h0, imem_req_valid}, 32'h0);
    end
  endtask

  task automatic chkResetOuts(input string tag);
    chk({tag, ".req_valid"},  {31'h0, imem_req_valid}, 32'h0);
    chk({tag, ".addr"},       imem_addr, 32'h0);
    chk({tag, ".inst_valid"}, {31'h0, inst_valid}, 32'h0);
    chk({tag, ".inst"},       inst, 32'h0);
    chk({tag, ".inst_pc"},    inst_pc, 32'h0);
    chk({tag, ".fault"},      {30'h0, inst_fault}, 32'h0);
  endtask

  initial begin
    logic [31:0] npc;
    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    imem_rsp_err = 1'b0; inst_ready = 1'b0; commit_valid = 1'b0; commit_npc = '0;
    pcM = RST_PC;
    step(); step();
    chkResetOuts("reset");

    // Release: one IDLE cycle, then request at the reset PC.
    rst_n = 1'b1;
    #1;
    chkResetOuts("idle");
    step();
    chk("first.req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("first.addr", imem_addr, RST_PC);
    chk("first.inst_valid", {31'h0, inst_valid}, 32'h0);

    // Directed test-plan sequence.
    fetch(3, 2, 32'h00100093, 1'b0, 2);
    commitTo(32'h80000004, 0);
    fetch(0, 0, 32'h00200113, 1'b0, 0);
    commitTo(32'h80000102, 1);
    deliver(1, 32'h0, 32'h80000102, 2'b10);
    commitTo(32'h80000200, 2);             // trap vector
    fetch(1, 1, 32'hdeadbeef, 1'b1, 2);    // access fault, commit in OUT ignored
    commitTo(32'h80000200, 0);             // self-loop refetch
    fetch(0, 3, 32'h00000013, 1'b0, 0);
    commitTo(32'h80000300, 0);

    // Reset while a read is outstanding, then a stale response in IDLE.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chkResetOuts("midreset");
    step();
    rst_n = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h12345678;
    step();
    imem_rsp_valid = 1'b0;
    pcM = RST_PC;
    chk("stale.inst_valid", {31'h0, inst_valid}, 32'h0);
    chk("stale.req_valid",  {31'h0, imem_req_valid}, 32'h1);
    chk("stale.addr",       imem_addr, RST_PC);
    fetch(1, 0, 32'h00500293, 1'b0, 1);

    // Randomized transactions.
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 5))
        0:       npc = pcM;                                     // self-loop
        1:       npc = {$urandom_range(0, 32'h3fffffff), 2'b00} | 32'h00000000;
        2:       npc = {$urandom_range(0, 32'h3fffffff), 2'(1 + $urandom_range(0, 2))};
        default: npc = pcM + {$urandom_range(0, 255), 2'b00} - 32'd512;
      endcase
      commitTo(npc, $urandom_range(0, 3));
      if (npc[1:0] != 2'b00) begin
        deliver($urandom_range(0, 2), 32'h0, npc, 2'b10);
        commitTo({$urandom, 2'b00} & 32'hfffffffc, $urandom_range(0, 2));
      end
      fetch($urandom_range(0, 3), $urandom_range(0, 4), $urandom,
            ($urandom_range(0, 4) == 0), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
